// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle for the multi-cycle MIPS main controller.
// master = controller side, slave = datapath/IR side.
interface mc_control_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       op_i;
    logic             mem_ready_i;
    logic             pc_write_o;
    logic             pc_write_cond_o;
    logic             i_or_d_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic             ir_write_o;
    logic             mem_to_reg_o;
    logic             reg_dst_o;
    logic             reg_write_o;
    logic             alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [1:0]       alu_op_o;
    logic [1:0]       pc_source_o;
    logic             ext_zero_o;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] retired_o;
    logic             illegal_o;

    modport master (
        input  op_i, mem_ready_i,
        output pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
               ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, pc_source_o, ext_zero_o, state_o,
               retired_o, illegal_o
    );

    modport slave (
        output op_i, mem_ready_i,
        input  pc_write_o, pc_write_cond_o, i_or_d_o, mem_read_o, mem_write_o,
               ir_write_o, mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, pc_source_o, ext_zero_o, state_o,
               retired_o, illegal_o
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Main controller of the multi-cycle MIPS datapath: sequences fetch/decode/
// execute/memory/writeback, selects the immediate extender mode and counts
// retired instructions.
// Optional feature: define MC_ILLEGAL_TRAP_EN to trap unknown opcodes in a
// sticky TRAP state (illegal_o = 1); otherwise they retire as NOPs.
module mc_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mc_control_if.master bus
);
    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] MEM_ADDR  = 4'd2;
    localparam logic [3:0] MEM_READ  = 4'd3;
    localparam logic [3:0] MEM_WB    = 4'd4;
    localparam logic [3:0] MEM_WRITE = 4'd5;
    localparam logic [3:0] R_EXEC    = 4'd6;
    localparam logic [3:0] R_WB      = 4'd7;
    localparam logic [3:0] BRANCH    = 4'd8;
    localparam logic [3:0] JUMP      = 4'd9;
    localparam logic [3:0] I_EXEC    = 4'd10;
    localparam logic [3:0] I_WB      = 4'd11;
`ifdef MC_ILLEGAL_TRAP_EN
    localparam logic [3:0] TRAP      = 4'd12;
`endif

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    logic [3:0]       state, state_n;
    logic             retire;
    logic [CNT_W-1:0] retired;

    // Next-state selection; retire marks every return to FETCH that completes an instruction.
    always_comb begin
        state_n = FETCH;
        retire  = 1'b0;
        case (state)
            FETCH:     state_n = bus.mem_ready_i ? DECODE : FETCH;
            DECODE: begin
                case (bus.op_i)
                    OP_RTYPE:                 state_n = R_EXEC;
                    OP_LW, OP_SW:             state_n = MEM_ADDR;
                    OP_BEQ:                   state_n = BRANCH;
                    OP_J:                     state_n = JUMP;
                    OP_ADDI, OP_SLTI, OP_ORI: state_n = I_EXEC;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_n = TRAP;
`else
                        state_n = FETCH;
                        retire  = 1'b1;
`endif
                    end
                endcase
            end
            MEM_ADDR:  state_n = (bus.op_i == OP_LW) ? MEM_READ : MEM_WRITE;
            MEM_READ:  state_n = bus.mem_ready_i ? MEM_WB : MEM_READ;
            MEM_WRITE: begin
                state_n = bus.mem_ready_i ? FETCH : MEM_WRITE;
                retire  = bus.mem_ready_i;
            end
            R_EXEC:    state_n = R_WB;
            I_EXEC:    state_n = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: begin
                state_n = FETCH;
                retire  = 1'b1;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            TRAP:      state_n = TRAP;
`endif
            default:   state_n = FETCH;
        endcase
    end

    // State register and retired-instruction counter (wraps naturally).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= FETCH;
            retired <= '0;
        end else begin
            state <= state_n;
            if (retire) retired <= retired + 1'b1;
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    logic illegal;

    // Sticky flag, set on the same edge that enters TRAP.
    always_ff @(posedge clk_i) begin
        if (rst_i)                illegal <= 1'b0;
        else if (state_n == TRAP) illegal <= 1'b1;
    end
    assign bus.illegal_o = illegal;
`else
    assign bus.illegal_o = 1'b0;
`endif

    // Moore-style control decode; FETCH alone looks at mem_ready_i for the IR/PC loads.
    always_comb begin
        bus.pc_write_o      = 1'b0;
        bus.pc_write_cond_o = 1'b0;
        bus.i_or_d_o        = 1'b0;
        bus.mem_read_o      = 1'b0;
        bus.mem_write_o     = 1'b0;
        bus.ir_write_o      = 1'b0;
        bus.mem_to_reg_o    = 1'b0;
        bus.reg_dst_o       = 1'b0;
        bus.reg_write_o     = 1'b0;
        bus.alu_src_a_o     = 1'b0;
        bus.alu_src_b_o     = 2'b00;
        bus.alu_op_o        = 2'b00;
        bus.pc_source_o     = 2'b00;
        case (state)
            FETCH: begin
                bus.mem_read_o  = 1'b1;
                bus.alu_src_b_o = 2'b01;
                bus.ir_write_o  = bus.mem_ready_i;
                bus.pc_write_o  = bus.mem_ready_i;
            end
            DECODE:    bus.alu_src_b_o = 2'b11;
            MEM_ADDR: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = 2'b10;
            end
            MEM_READ: begin
                bus.i_or_d_o   = 1'b1;
                bus.mem_read_o = 1'b1;
            end
            MEM_WRITE: begin
                bus.i_or_d_o    = 1'b1;
                bus.mem_write_o = 1'b1;
            end
            MEM_WB: begin
                bus.reg_write_o  = 1'b1;
                bus.mem_to_reg_o = 1'b1;
            end
            R_EXEC: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_op_o    = 2'b10;
            end
            R_WB: begin
                bus.reg_write_o = 1'b1;
                bus.reg_dst_o   = 1'b1;
            end
            BRANCH: begin
                bus.alu_src_a_o     = 1'b1;
                bus.alu_op_o        = 2'b01;
                bus.pc_write_cond_o = 1'b1;
                bus.pc_source_o     = 2'b01;
            end
            JUMP: begin
                bus.pc_write_o  = 1'b1;
                bus.pc_source_o = 2'b10;
            end
            I_EXEC: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = 2'b10;
                bus.alu_op_o    = 2'b11;
            end
            I_WB:      bus.reg_write_o = 1'b1;
            default: ;
        endcase
        // Reset wins over any state so nothing is enabled during reset.
        if (rst_i) begin
            bus.pc_write_o      = 1'b0;
            bus.pc_write_cond_o = 1'b0;
            bus.i_or_d_o        = 1'b0;
            bus.mem_read_o      = 1'b0;
            bus.mem_write_o     = 1'b0;
            bus.ir_write_o      = 1'b0;
            bus.mem_to_reg_o    = 1'b0;
            bus.reg_dst_o       = 1'b0;
            bus.reg_write_o     = 1'b0;
            bus.alu_src_a_o     = 1'b0;
            bus.alu_src_b_o     = 2'b00;
            bus.alu_op_o        = 2'b00;
            bus.pc_source_o     = 2'b00;
        end
    end

    assign bus.ext_zero_o = (state != FETCH) && (bus.op_i == OP_ORI);
    assign bus.state_o    = state;
    assign bus.retired_o  = retired;
endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: reset, a latency table, hand
// sequences for memory stalls / mid-instruction reset / illegal opcodes, and
// random instruction streams checked against a phase-list reference model.
// A second instance with CNT_W = 4 exercises counter wrap.
module tb_mc_control_fsm;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cnt   = 0;     // model retired count (full width)
    logic ill_exp = 1'b0;

    always #5 clk = ~clk;

    mc_control_if #(.CNT_W(32)) bus ();
    mc_control_if #(.CNT_W(4))  bus4 ();

    mc_control_fsm #(.CNT_W(32)) dut  (.clk_i(clk), .rst_i(rst), .bus(bus));
    mc_control_fsm #(.CNT_W(4))  dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));

    assign bus4.op_i        = bus.op_i;
    assign bus4.mem_ready_i = bus.mem_ready_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control vector in a fixed order:
    // pc_write pc_write_cond i_or_d mem_read mem_write ir_write mem_to_reg reg_dst reg_write src_a src_b alu_op pc_source
    function automatic logic [15:0] ctrl_act();
        return {bus.pc_write_o, bus.pc_write_cond_o, bus.i_or_d_o, bus.mem_read_o,
                bus.mem_write_o, bus.ir_write_o, bus.mem_to_reg_o, bus.reg_dst_o,
                bus.reg_write_o, bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o,
                bus.pc_source_o};
    endfunction

    // Control settings for each named state, straight from the state descriptions.
    function automatic logic [15:0] ctrl_exp(input int s, input logic r);
        logic pw = 0, pwc = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
        logic [1:0] sb = 0, op = 0, ps = 0;
        case (s)
            0:  begin mr = 1; sb = 2'b01; irw = r; pw = r; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin iod = 1; mr = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin iod = 1; mw = 1; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; op = 2'b01; pwc = 1; ps = 2'b01; end
            9:  begin pw = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; op = 2'b11; end
            11: rw = 1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps};
    endfunction

    function automatic bit is_mem(input int s);
        return (s == 0) || (s == 3) || (s == 5);
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'd0, 6'd2, 6'd4, 6'd8, 6'd10, 6'd13, 6'd35, 6'd43};
    endfunction

    // Full per-cycle comparison against the model; call #1 after a negedge.
    task automatic check_cycle(input int s, input logic r);
        logic [31:0] c32;
        c32 = cnt;
        chk("state", 32'(bus.state_o), 32'(s));
        chk("ctrl", 32'(ctrl_act()), 32'(ctrl_exp(s, r)));
        chk("ext_zero", 32'(bus.ext_zero_o), 32'((s != 0) && (bus.op_i == 6'd13)));
        chk("retired", bus.retired_o, c32);
        chk("retired4", 32'(bus4.retired_o), 32'(c32[3:0]));
        chk("illegal", 32'(bus.illegal_o), 32'(ill_exp));
        chk("rd_wr_excl", 32'(bus.mem_read_o & bus.mem_write_o), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: an instruction is an ordered list of states; memory
    // states repeat until ready is seen, then the instruction retires.
    task automatic run_instr(input logic [5:0] op);
        int ph[$];
        ph.push_back(0);
        ph.push_back(1);
        case (op)
            6'd35: begin ph.push_back(2); ph.push_back(3); ph.push_back(4); end
            6'd43: begin ph.push_back(2); ph.push_back(5); end
            6'd0:  begin ph.push_back(6); ph.push_back(7); end
            6'd4:  ph.push_back(8);
            6'd2:  ph.push_back(9);
            6'd8, 6'd10, 6'd13: begin ph.push_back(10); ph.push_back(11); end
            default: ;
        endcase
        bus.op_i = op;
        foreach (ph[i]) begin
            logic r;
            int guard = 0;
            do begin
                r = is_mem(ph[i]) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
                bus.mem_ready_i = r;
                #1;
                check_cycle(ph[i], r);
                tick();
                guard++;
            end while (is_mem(ph[i]) && !r && guard < 50);
        end
        cnt++;
    endtask

    typedef struct {
        logic [5:0] op;
        int         lat;
        logic       ext_dec;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int   n_mw, n_rw, waits, cyc, base;
        logic ext_seen;

        tbl[0] = '{6'd35, 5, 1'b0};
        tbl[1] = '{6'd43, 4, 1'b0};
        tbl[2] = '{6'd0,  4, 1'b0};
        tbl[3] = '{6'd4,  3, 1'b0};
        tbl[4] = '{6'd2,  3, 1'b0};
        tbl[5] = '{6'd8,  4, 1'b0};
        tbl[6] = '{6'd10, 4, 1'b0};
        tbl[7] = '{6'd13, 4, 1'b1};

        // Reset held two cycles.
        bus.op_i = 6'd35;
        bus.mem_ready_i = 1'b1;
        @(negedge clk);
        tick();
        #1;
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_retired", bus.retired_o, 32'd0);
        chk("rst_ctrl", 32'(ctrl_act()), 32'd0);
        chk("rst_illegal", 32'(bus.illegal_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Latency table, ready tied high.
        foreach (tbl[i]) begin
            bus.op_i = tbl[i].op;
            bus.mem_ready_i = 1'b1;
            base = cnt;
            cyc = 0;
            ext_seen = 1'b0;
            do begin
                #1;
                if (bus.state_o == 4'd1) ext_seen = bus.ext_zero_o;
                tick();
                cyc++;
            end while (bus.state_o != 4'd0 && cyc < 20);
            cnt++;
            chk("tbl_latency", 32'(cyc), 32'(tbl[i].lat));
            chk("tbl_ext_dec", 32'(ext_seen), 32'(tbl[i].ext_dec));
            #1;
            chk("tbl_retired", bus.retired_o, 32'(base + 1));
        end

        // sw with ready low for 3 cycles in MEM_WRITE.
        bus.op_i = 6'd43;
        n_mw = 0; n_rw = 0; waits = 0; cyc = 0;
        base = cnt;
        do begin
            bus.mem_ready_i = (bus.state_o == 4'd5) ? (waits >= 3) : 1'b1;
            #1;
            if (bus.mem_write_o) n_mw++;
            if (bus.reg_write_o) n_rw++;
            if (bus.state_o == 4'd5) waits++;
            tick();
            cyc++;
        end while (bus.state_o != 4'd0 && cyc < 20);
        cnt++;
        chk("sw_mem_write_cycles", 32'(n_mw), 32'd4);
        chk("sw_reg_write", 32'(n_rw), 32'd0);
        #1;
        chk("sw_retired", bus.retired_o, 32'(base + 1));

        // Reset in the middle of a lw abandons it.
        bus.op_i = 6'd35;
        bus.mem_ready_i = 1'b1;
        tick(); tick(); tick();
        #1;
        chk("mid_state", 32'(bus.state_o), 32'd3);
        rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", 32'(ctrl_act()), 32'd0);
        tick();
        #1;
        chk("mid_rst_state", 32'(bus.state_o), 32'd0);
        chk("mid_rst_retired", bus.retired_o, 32'd0);
        cnt = 0;
        @(negedge clk);
        rst = 1'b0;

        // Random instruction stream; more than 16 retires so retired4 wraps.
        for (int k = 0; k < 60; k++) begin
            logic [5:0] op;
            op = 6'($urandom_range(0, 63));
`ifdef MC_ILLEGAL_TRAP_EN
            while (!is_legal(op)) op = 6'($urandom_range(0, 63));
`else
            if ($urandom_range(0, 3) != 0)
                while (!is_legal(op)) op = 6'($urandom_range(0, 63));
`endif
            run_instr(op);
        end
        chk("wrap_seen", 32'(cnt >= 16), 32'd1);

        // Illegal opcode 63.
`ifdef MC_ILLEGAL_TRAP_EN
        bus.op_i = 6'd63;
        bus.mem_ready_i = 1'b1;
        #1; check_cycle(0, 1'b1); tick();
        #1; check_cycle(1, 1'b1); tick();
        ill_exp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.mem_ready_i = 1'($urandom_range(0, 1));
            #1;
            check_cycle(12, bus.mem_ready_i);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cnt = 0;
        ill_exp = 1'b0;
        #1;
        chk("trap_cleared", 32'(bus.illegal_o), 32'd0);
        chk("trap_rst_state", 32'(bus.state_o), 32'd0);
`else
        base = cnt;
        run_instr(6'd63);
        #1;
        chk("nop_state", 32'(bus.state_o), 32'd0);
        chk("nop_retired", bus.retired_o, 32'(base + 1));
        chk("nop_illegal", 32'(bus.illegal_o), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
